display_pager: RTL and testbench

- Parametrised successor to the fixed two-page clock display driver.
- Drives DIGITS common-anode 7-segment digits from PAGES pages of BCD nibbles.
- Auto mode rotates pages on a timer. Adjust mode freezes on the page holding the selected digit and blinks that digit.
- Sits between the timekeeping/adjust logic and the board HEX/LEDR pins.
- All outputs are registered.

---
 rtl/display_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 38 +++
 rtl/display_pager.sv | 141 ++++++++++++++
 tb/tb_display_pager.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and glyph constants for the paged 7-segment display.
package display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  localparam seg7_t SEG_0 = 7'b1000000;
  localparam seg7_t SEG_1 = 7'b1111001;
  localparam seg7_t SEG_2 = 7'b0100100;
  localparam seg7_t SEG_3 = 7'b0110000;
  localparam seg7_t SEG_4 = 7'b0011001;
  localparam seg7_t SEG_5 = 7'b0010010;
  localparam seg7_t SEG_6 = 7'b0000010;
  localparam seg7_t SEG_7 = 7'b1111000;
  localparam seg7_t SEG_8 = 7'b0000000;
  localparam seg7_t SEG_9 = 7'b0010000;
  localparam seg7_t SEG_A = 7'b0001000;
  localparam seg7_t SEG_B = 7'b0000011;
  localparam seg7_t SEG_C = 7'b1000110;
  localparam seg7_t SEG_D = 7'b0100001;
  localparam seg7_t SEG_E = 7'b0000110;
  localparam seg7_t SEG_F = 7'b0001110;

  typedef enum logic {
    AUTO,
    ADJUST
  } disp_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low segments (g..a) with a blank override.
// DISPLAY_PAGER_HEX_GLYPH_EN enables A-F glyphs for nibbles 10-15.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0:    seg = SEG_0;
        4'h1:    seg = SEG_1;
        4'h2:    seg = SEG_2;
        4'h3:    seg = SEG_3;
        4'h4:    seg = SEG_4;
        4'h5:    seg = SEG_5;
        4'h6:    seg = SEG_6;
        4'h7:    seg = SEG_7;
        4'h8:    seg = SEG_8;
        4'h9:    seg = SEG_9;
`ifdef DISPLAY_PAGER_HEX_GLYPH_EN
        4'hA:    seg = SEG_A;
        4'hB:    seg = SEG_B;
        4'hC:    seg = SEG_C;
        4'hD:    seg = SEG_D;
        4'hE:    seg = SEG_E;
        4'hF:    seg = SEG_F;
`endif
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/display_pager.sv
// Paged 7-segment driver: auto page rotation, adjust mode with digit blink.
// Optional DISPLAY_PAGER_HEX_GLYPH_EN shows hex glyphs for nibbles 10-15.
module display_pager
  import display_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int PAGES    = 2,
  parameter int CLK_HZ   = 50_000_000,
  parameter int PAGE_SEC = 2,
  parameter int BLINK_HZ = 2
) (
  input  logic                                  CLOCK_50,
  input  logic                                  reset,
  input  logic [PAGES*DIGITS*4-1:0]             page_data,
  input  logic                                  adjust,
  input  logic [clog2_min1(PAGES*DIGITS)-1:0]   select,
  output logic [DIGITS*7-1:0]                   HEX,
  output logic [PAGES-1:0]                      LEDR
);

  localparam int TOTAL      = PAGES * DIGITS;
  localparam int SEL_W      = clog2_min1(TOTAL);
  localparam int PG_W       = clog2_min1(PAGES);
  localparam int HALF       = CLK_HZ / (2 * BLINK_HZ);
  localparam int PAGE_TICKS = CLK_HZ * PAGE_SEC;
  localparam int PC_W       = clog2_min1(PAGE_TICKS);
  localparam int BC_W       = clog2_min1(HALF);

  localparam logic [PC_W-1:0]  PAGE_TC   = PC_W'(PAGE_TICKS - 1);
  localparam logic [BC_W-1:0]  BLINK_TC  = BC_W'(HALF - 1);
  localparam logic [PG_W-1:0]  PAGE_LAST = PG_W'(PAGES - 1);
  localparam logic [SEL_W:0]   TOTAL_X   = (SEL_W + 1)'(TOTAL);

  disp_state_e         state_q, state_d;
  logic [PG_W-1:0]     page_q, page_d;
  logic [PC_W-1:0]     page_cnt_q, page_cnt_d;
  logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_on_q, blink_on_d;
  logic [DIGITS*7-1:0] hex_q, hex_d;
  logic [PAGES-1:0]    ledr_q, ledr_d;

  logic                sel_ok;
  logic [PG_W-1:0]     sel_page;
  logic [DIGITS*4-1:0] page_nib;
  logic [DIGITS-1:0]   blank;
  seg7_t               seg [DIGITS];

  assign sel_ok   = {1'b0, select} < TOTAL_X;
  assign sel_page = PG_W'(int'(select) / DIGITS);

  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    page_cnt_d  = page_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    unique case (state_q)
      AUTO: begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (adjust) begin
          state_d = ADJUST;
          if (sel_ok) page_d = sel_page;
        end else if (page_cnt_q == PAGE_TC) begin
          page_cnt_d = '0;
          page_d     = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
        end else begin
          page_cnt_d = page_cnt_q + 1'b1;
        end
      end
      ADJUST: begin
        if (!adjust) begin
          // Restart the page timer so the frozen page gets a full period.
          state_d     = AUTO;
          page_cnt_d  = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else begin
          if (sel_ok) page_d = sel_page;
          if (blink_cnt_q == BLINK_TC) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = AUTO;
    endcase
  end

  assign page_nib = page_data[int'(page_d)*DIGITS*4 +: DIGITS*4];

  always_comb begin
    blank = '0;
    for (int d = 0; d < DIGITS; d++) begin
      blank[d] = !blink_on_d &&
                 (int'(select) == int'(page_d) * DIGITS + d);
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    seg7_decode u_dec (
      .nibble (page_nib[4*d +: 4]),
      .blank  (blank[d]),
      .seg    (seg[d])
    );
  end

  always_comb begin
    hex_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      hex_d[7*d +: 7] = seg[d];
    end
    ledr_d = blink_on_d ? (PAGES'(1) << page_d) : '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= AUTO;
      page_q      <= '0;
      page_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      hex_q       <= '1;
      ledr_q      <= '0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      page_cnt_q  <= page_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      hex_q       <= hex_d;
      ledr_q      <= ledr_d;
    end
  end

  assign HEX  = hex_q;
  assign LEDR = ledr_q;

endmodule

// File: tb/tb_display_pager.sv
// Random + directed bench for display_pager against a behavioural model.
module tb_display_pager;

  localparam int DIGITS = 4;
  localparam int HALF   = 5;
  localparam int PERIOD = 20;

`ifdef DISPLAY_PAGER_HEX_GLYPH_EN
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        adjust;
  logic [3:0]  sel4;
  logic [47:0] pd;
  logic [27:0] hex_a, hex_b;
  logic [1:0]  ledr_a;
  logic [2:0]  ledr_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  display_pager #(
    .DIGITS(4), .PAGES(2), .CLK_HZ(20), .PAGE_SEC(1), .BLINK_HZ(2)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .page_data (pd[31:0]),
    .adjust    (adjust),
    .select    (sel4[2:0]),
    .HEX       (hex_a),
    .LEDR      (ledr_a)
  );

  display_pager #(
    .DIGITS(4), .PAGES(3), .CLK_HZ(20), .PAGE_SEC(1), .BLINK_HZ(2)
  ) dut3 (
    .CLOCK_50  (clk),
    .reset     (reset),
    .page_data (pd),
    .adjust    (adjust),
    .select    (sel4),
    .HEX       (hex_b),
    .LEDR      (ledr_b)
  );

  task automatic check(input string name, input logic [27:0] act,
                       input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time spent on the page and time since entering adjust.
  int          m_page [2];
  int          m_at   [2];
  int          m_bt   [2];
  bit          m_adj  [2];
  logic [27:0] exp_hex  [2];
  logic [2:0]  exp_ledr [2];
  bit          model_valid = 0;

  int np, tot, sel, nib;
  bit on;
  logic [6:0] g;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      np  = (i == 0) ? 2 : 3;
      tot = np * DIGITS;
      sel = (i == 0) ? int'(sel4[2:0]) : int'(sel4);
      if (reset) begin
        m_page[i] = 0; m_at[i] = 0; m_bt[i] = 0; m_adj[i] = 0;
        exp_hex[i] = '1; exp_ledr[i] = '0;
      end else begin
        if (!m_adj[i]) begin
          if (adjust) begin
            m_adj[i] = 1; m_bt[i] = 0;
            if (sel < tot) m_page[i] = sel / DIGITS;
          end else begin
            m_at[i]++;
            if (m_at[i] == PERIOD) begin
              m_at[i] = 0;
              m_page[i] = (m_page[i] + 1) % np;
            end
          end
        end else begin
          if (adjust) begin
            m_bt[i]++;
            if (sel < tot) m_page[i] = sel / DIGITS;
          end else begin
            m_adj[i] = 0; m_at[i] = 0;
          end
        end
        on = !m_adj[i] || ((m_bt[i] / HALF) % 2 == 0);
        for (int d = 0; d < DIGITS; d++) begin
          nib = int'(pd[(m_page[i]*DIGITS + d)*4 +: 4]);
          g = GLYPH[nib];
          if (!on && sel == m_page[i]*DIGITS + d) g = 7'h7F;
          exp_hex[i][7*d +: 7] = g;
        end
        exp_ledr[i] = on ? 3'(1 << m_page[i]) : 3'b000;
      end
    end
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("hex_p2",  hex_a,  exp_hex[0]);
      check("ledr_p2", {26'b0, ledr_a}, {25'b0, exp_ledr[0]});
      check("hex_p3",  hex_b,  exp_hex[1]);
      check("ledr_p3", {25'b0, ledr_b}, {25'b0, exp_ledr[1]});
    end
  end

  initial begin
    reset = 1'b1; adjust = 1'b0; sel4 = 4'd0;
    pd = 48'hBA98_7654_3210;
    repeat (3) @(negedge clk);
    check("rst_hex",  hex_a, 28'hFFFFFFF);
    check("rst_ledr", {26'b0, ledr_a}, 28'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rel_hex",  hex_a, {7'h30, 7'h24, 7'h79, 7'h40});
    check("rel_ledr", {26'b0, ledr_a}, 28'd1);
    repeat (19) @(negedge clk);
    check("rot1_ledr", {26'b0, ledr_a}, 28'd2);
    check("rot1_hex",  hex_a, {7'h78, 7'h02, 7'h12, 7'h19});
    repeat (20) @(negedge clk);
    check("rot2_ledr", {26'b0, ledr_a}, 28'd1);
    #1 adjust = 1'b1; sel4 = 4'd6;
    @(negedge clk);
    check("adj_ledr", {26'b0, ledr_a}, 28'd2);
    check("adj_hex",  hex_a, {7'h78, 7'h02, 7'h12, 7'h19});
    repeat (5) @(negedge clk);
    check("blink_hex",  hex_a, {7'h78, 7'h7F, 7'h12, 7'h19});
    check("blink_ledr", {26'b0, ledr_a}, 28'd0);
    #1 sel4 = 4'hE;
    @(negedge clk);
    check("oor_hex3",  hex_b, {7'h78, 7'h02, 7'h12, 7'h19});
    check("oor_ledr3", {25'b0, ledr_b}, 28'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_hex",  hex_a, 28'hFFFFFFF);
    check("midrst_ledr", {26'b0, ledr_a}, 28'd0);
    #1 reset = 1'b0; adjust = 1'b0; sel4 = 4'd0;
    repeat (7) @(negedge clk);
    #1 adjust = 1'b1; sel4 = 4'd5;
    repeat (3) @(negedge clk);
    #1 adjust = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_ledr", {26'b0, ledr_a}, 28'd2);
    @(negedge clk);
    check("adv_ledr",  {26'b0, ledr_a}, 28'd1);
    #1 pd = 48'h0000_BBBB_BBBB;
    @(negedge clk);
`ifdef DISPLAY_PAGER_HEX_GLYPH_EN
    check("glyph_b", hex_a, {4{7'h03}});
`else
    check("glyph_b", hex_a, {4{7'h7F}});
`endif
    repeat (1500) begin
      #1;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) adjust = ~adjust;
      if ($urandom_range(0, 5) == 0) sel4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) pd = {16'($urandom), $urandom};
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
